// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage between the instruction cache and the IF/ID boundary. It holds
// the fetch PC, issues one cache read per cycle when allowed, and tracks the
// cache's 1-cycle read latency. A 1-entry skid buffer holds the returning
// instruction while decode is stalled. Redirects from later stages discard
// any fetched instructions and restart fetch at the new target.
//
// Ports:
//   clk             system clock; all state changes on the rising edge
//   reset           synchronous, active-high reset
//   run             1 = new fetches may be issued; 0 = drain only
//   id_stall        decode cannot accept an instruction this cycle
//   redirect_valid  control-flow change from a later stage
//   redirect_pc     new fetch target (low two bits ignored, flagged if set)
//   icache_enable   cache read enable
//   icache_addr     cache byte address (always the current fetch PC)
//   icache_data     cache read data, valid one cycle after icache_enable
//   if_valid        if_instr / if_pc / if_pc_plus4 are valid for decode
//   if_instr        fetched instruction
//   if_pc           address of if_instr
//   if_pc_plus4     if_pc + 4, modulo 2^ADDR_WIDTH
//   misalign_err    one-cycle pulse after a redirect to a non-word address
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  id_stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  icache_enable,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic [DATA_WIDTH-1:0] icache_data,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus4,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_valid;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0] skid_pc;

  logic issue;
  logic skid_capture;

  // A new read is only issued when decode will be able to take the previous
  // one, so the skid buffer and the in-flight read are never both occupied.
  assign issue         = run & ~id_stall & ~redirect_valid & ~reset;
  assign skid_capture  = inflight_valid & id_stall & ~skid_valid & ~redirect_valid;

  assign icache_enable = issue;
  assign icache_addr   = pc_q;

  // Control state. Redirect outranks everything except reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      inflight_valid <= 1'b0;
      skid_valid     <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        pc_q           <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        inflight_valid <= 1'b0;
        skid_valid     <= 1'b0;
      end else begin
        inflight_valid <= issue;
        if (issue) begin
          pc_q <= pc_q + PC_STEP;
        end
        if (skid_capture) begin
          skid_valid <= 1'b1;
        end else if (~id_stall) begin
          skid_valid <= 1'b0;
        end
      end
    end
  end

  // Payload registers are qualified by the valid bits above, so they carry
  // no reset.
  // NOTE: data-path registers whose contents are never observed while their
  // valid bit is low are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc <= pc_q;
    end
    if (skid_capture) begin
      skid_instr <= icache_data;
      skid_pc    <= inflight_pc;
    end
  end

  // Output mux: the skid entry is always older than any in-flight read.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    if_valid    = (skid_valid | inflight_valid) & ~redirect_valid & ~reset;
    if_instr    = '0;
    if_pc       = '0;
    if_pc_plus4 = '0;
    if (if_valid) begin
      if (skid_valid) begin
        if_instr = skid_instr;
        if_pc    = skid_pc;
      end else begin
        if_instr = icache_data;
        if_pc    = inflight_pc;
      end
      if_pc_plus4 = if_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench. A transaction-level model keeps the next fetch PC and
// a queue of fetched-but-undelivered PCs; instruction words are a pure
// function of address. Every cycle all outputs of the main instance are
// compared against that model. A second instance with RESET_PC near the top
// of the address space checks PC wraparound with literal expectations.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_enable;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;

  logic        w_reset;
  logic        w_run;
  logic        w_stall;
  logic        w_redir;
  logic [31:0] w_rpc;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_p4;
  logic        w_mis;

  instruction_fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_enable  (icache_enable),
    .icache_addr    (icache_addr),
    .icache_data    (icache_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .misalign_err   (misalign_err)
  );

  instruction_fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'hFFFF_FFF8)
  ) u_wrap (
    .clk            (clk),
    .reset          (w_reset),
    .run            (w_run),
    .id_stall       (w_stall),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc),
    .icache_enable  (w_en),
    .icache_addr    (w_addr),
    .icache_data    (w_data),
    .if_valid       (w_valid),
    .if_instr       (w_instr),
    .if_pc          (w_pc),
    .if_pc_plus4    (w_p4),
    .misalign_err   (w_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];
  logic        m_mis;

  // Cache read requests sampled mid-cycle, answered after the next edge
  logic        rd_en,  w_rd_en;
  logic [31:0] rd_addr, w_rd_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all main-instance outputs against the model (at negedge).
  task automatic tick_check();
    logic        exp_valid;
    logic [31:0] exp_pc;
    @(negedge clk);
    exp_valid = (pend_q.size() != 0) && !redirect_valid && !reset;
    exp_pc    = exp_valid ? pend_q[0] : 32'h0;
    check("if_valid",      {31'b0, if_valid},      {31'b0, exp_valid});
    check("if_pc",         if_pc,                  exp_pc);
    check("if_instr",      if_instr,               exp_valid ? mem_word(exp_pc) : 32'h0);
    check("if_pc_plus4",   if_pc_plus4,            exp_valid ? exp_pc + 32'd4 : 32'h0);
    check("icache_enable", {31'b0, icache_enable},
          {31'b0, run && !id_stall && !redirect_valid && !reset});
    check("icache_addr",   icache_addr,            m_pc);
    check("misalign_err",  {31'b0, misalign_err},  {31'b0, m_mis});
    check("skid_inflight_exclusive",
          {31'b0, dut.skid_valid && dut.inflight_valid}, 32'h0);
    rd_en     = icache_enable;
    rd_addr   = icache_addr;
    w_rd_en   = w_en;
    w_rd_addr = w_addr;
  endtask

  // Advance the model by one clock using the current inputs, then clock.
  task automatic tick_advance();
    if (reset) begin
      m_pc  = 32'h0;
      pend_q.delete();
      m_mis = 1'b0;
    end else if (redirect_valid) begin
      pend_q.delete();
      m_pc  = {redirect_pc[31:2], 2'b00};
      m_mis = |redirect_pc[1:0];
    end else begin
      m_mis = 1'b0;
      if (pend_q.size() != 0 && !id_stall) void'(pend_q.pop_front());
      if (run && !id_stall) begin
        pend_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    icache_data = rd_en   ? mem_word(rd_addr)   : $urandom();
    w_data      = w_rd_en ? mem_word(w_rd_addr) : $urandom();
  endtask

  task automatic step();
    tick_check();
    tick_advance();
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; icache_data = 32'h0;
    w_reset = 1'b1; w_run = 1'b1; w_stall = 1'b0;
    w_redir = 1'b0; w_rpc = 32'h0; w_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 32'h0; m_mis = 1'b0; pend_q.delete();

    step();  // reset still asserted
    reset = 1'b0; w_reset = 1'b0; run = 1'b1;

    // First fetch and wraparound instance
    tick_check();
    check("A_en", {31'b0, icache_enable}, 32'h1);
    check("A_addr", icache_addr, 32'h0);
    check("A_w_addr", w_addr, 32'hFFFF_FFF8);
    check("A_w_valid", {31'b0, w_valid}, 32'h0);
    tick_advance();
    tick_check();
    check("B_valid", {31'b0, if_valid}, 32'h1);
    check("B_pc", if_pc, 32'h0);
    check("B_instr", if_instr, 32'h1000_0000);
    check("B_p4", if_pc_plus4, 32'h4);
    check("B_w_pc", w_pc, 32'hFFFF_FFF8);
    check("B_w_instr", w_instr, 32'h4FFF_FFFE);
    tick_advance();
    tick_check();
    check("C_w_pc", w_pc, 32'hFFFF_FFFC);
    check("C_w_p4", w_p4, 32'h0);
    tick_advance();
    tick_check();
    check("D_w_pc", w_pc, 32'h0);
    check("D_w_instr", w_instr, 32'h1000_0000);
    tick_advance();
    step();

    // Decode stall for three cycles: PC 0x10 held via skid
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_check();
      check("stall_valid", {31'b0, if_valid}, 32'h1);
      check("stall_pc", if_pc, 32'h10);
      check("stall_en", {31'b0, icache_enable}, 32'h0);
      tick_advance();
    end
    id_stall = 1'b0;
    tick_check();
    check("I_pc", if_pc, 32'h10);
    check("I_addr", icache_addr, 32'h14);
    tick_advance();
    tick_check();
    check("J_pc", if_pc, 32'h14);
    tick_advance();

    // Redirect to 0x80
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick_check();
    check("K_valid", {31'b0, if_valid}, 32'h0);
    tick_advance();
    redirect_valid = 1'b0;
    tick_check();
    check("L_valid", {31'b0, if_valid}, 32'h0);
    check("L_addr", icache_addr, 32'h80);
    tick_advance();
    tick_check();
    check("M_pc", if_pc, 32'h80);
    tick_advance();
    tick_check();
    check("N_pc", if_pc, 32'h84);
    tick_advance();

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick_check();
    check("O_mis", {31'b0, misalign_err}, 32'h0);
    tick_advance();
    redirect_valid = 1'b0;
    tick_check();
    check("P_mis", {31'b0, misalign_err}, 32'h1);
    check("P_addr", icache_addr, 32'h100);
    tick_advance();
    tick_check();
    check("Q_mis", {31'b0, misalign_err}, 32'h0);
    check("Q_pc", if_pc, 32'h100);
    tick_advance();

    // Reset while stalled with the skid buffer full
    id_stall = 1'b1;
    tick_check();
    check("R_pc", if_pc, 32'h104);
    tick_advance();
    reset = 1'b1;
    tick_check();
    check("S_skid_full", {31'b0, dut.skid_valid}, 32'h1);
    check("S_valid", {31'b0, if_valid}, 32'h0);
    tick_advance();
    reset = 1'b0;
    tick_check();
    check("T_valid", {31'b0, if_valid}, 32'h0);
    check("T_skid", {31'b0, dut.skid_valid}, 32'h0);
    check("T_addr", icache_addr, 32'h0);
    tick_advance();
    id_stall = 1'b0;
    tick_check();
    check("U_en", {31'b0, icache_enable}, 32'h1);
    tick_advance();
    tick_check();
    check("V_pc", if_pc, 32'h0);
    tick_advance();

    // Redirect coinciding with a stall
    redirect_valid = 1'b1; redirect_pc = 32'h200; id_stall = 1'b1;
    step();
    redirect_valid = 1'b0;
    tick_check();
    check("X_en", {31'b0, icache_enable}, 32'h0);
    check("X_addr", icache_addr, 32'h200);
    tick_advance();
    id_stall = 1'b0;
    tick_check();
    check("Y_en", {31'b0, icache_enable}, 32'h1);
    check("Y_addr", icache_addr, 32'h200);
    tick_advance();
    tick_check();
    check("Z_pc", if_pc, 32'h200);
    tick_advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      run            = ($urandom_range(0, 9) != 0);
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0)
        redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else
        redirect_pc = 32'($urandom_range(0, 1023));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the on-chip instruction cache and feeds the IF/ID boundary.
- Owns the PC and drives the cache enable/address.
- Tracks the cache's 1-cycle read latency and delivers instruction+PC with a valid flag to decode.
- Absorbs decode backpressure with a 1-entry skid buffer and services branch/jump redirects from later stages.

Parameters:
ADDR_WIDTH, 32, PC/cache address width
DATA_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset (word-aligned)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = fetch allowed; 0 = no new fetches issued, delivered instructions still drained
id_stall  in  1  decode cannot accept this cycle
redirect_valid  in  1  control-flow change from a later stage
redirect_pc  in  ADDR_WIDTH  new fetch target
icache_enable  out  1  cache read enable
icache_addr  out  ADDR_WIDTH  cache byte address (= pc_q)
icache_data  in  DATA_WIDTH  cache data_out, valid 1 cycle after enable
if_valid  out  1  if_instr/if_pc valid to decode
if_instr  out  DATA_WIDTH  fetched instruction
if_pc  out  ADDR_WIDTH  address of if_instr
if_pc_plus4  out  ADDR_WIDTH  if_pc + 4 (mod 2^ADDR_WIDTH)
misalign_err  out  1  1-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- State: pc_q, inflight_valid, inflight_pc, skid_valid, skid_instr, skid_pc.
- Reset (synchronous, overrides all): pc_q=RESET_PC, inflight_valid=0, skid_valid=0, misalign_err=0; if_valid=0, icache_enable=0 during reset.
- Reset mid-operation discards inflight and skid contents; nothing is delivered after it.
- issue = run & !id_stall & !redirect_valid & !reset.
- icache_enable = issue; icache_addr = pc_q at all times.
- On issue: inflight_pc<=pc_q, inflight_valid<=1, pc_q<=pc_q+4 (wraps to 0 past 2^ADDR_WIDTH-4). Otherwise inflight_valid<=0.
- Latency: address issued in cycle N -> if_valid with that instruction in cycle N+1 (if_instr=icache_data, if_pc=inflight_pc).
- Output mux:
  - if_valid = (skid_valid | inflight_valid) & !redirect_valid.
  - Source is skid when skid_valid, else inflight/icache_data.
  - if_pc_plus4 = if_pc+4.
  - All data outputs are 0 when if_valid=0.
- Transfer to decode = if_valid & !id_stall.
- Skid capture: inflight_valid & id_stall & !skid_valid & !redirect_valid -> skid <= {icache_data, inflight_pc}. Skid is held while id_stall and cleared on transfer.
- Invariant: skid_valid and inflight_valid are never both 1, because issue needs !id_stall and capture needs id_stall. The bench asserts this.
- Redirect (highest priority after reset) in cycle N:
  - pc_q<=redirect_pc with bits[1:0] forced 0; inflight and skid cleared; if_valid=0 in N; no issue in N.
  - Target fetched in N+1 if issue conditions hold; first target instruction valid in N+2.
- misalign_err <= redirect_valid & |redirect_pc[1:0] (registered, 1 cycle).
- Simultaneous redirect + id_stall: redirect wins; pc_q updated; issue waits for !id_stall.
- run=0: pc_q frozen; a pending inflight/skid entry is still delivered normally. run re-asserted: resumes at pc_q with no skipped or duplicated PCs.
- Every PC is delivered exactly once and in order, except PCs killed by redirect.

Test Plan:
- Reset then run=1, no stalls, memory word k = 0x1000_0000+k -> if_valid from cycle 1, if_pc 0,4,8,... one per cycle, if_instr matches, if_pc_plus4 = if_pc+4.
- id_stall high for cycles 5-7 -> instruction at PC 0x10 held on outputs via skid, icache_enable=0 during 5-7, delivery resumes 0x10,0x14 with no gap/duplicate.
- redirect_valid with redirect_pc=0x80 in cycle 6 -> if_valid=0 in cycle 6 and 7, if_pc=0x80 valid in cycle 8, then 0x84; wrong-path PCs never delivered.
- redirect_pc=0x83 -> fetch from 0x80, misalign_err pulses exactly one cycle.
- RESET_PC=0xFFFF_FFF8, free run -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 of FFFF_FFFC = 0.
- reset asserted during id_stall with skid full -> cycle after: if_valid=0, skid empty, fetch restarts at RESET_PC; also redirect+id_stall same cycle -> target issued only on first !id_stall cycle.
